// File: rtl/bath_lock_ctrl_pkg.sv
// Shared types for the bathysphere lock sequencer: state/direction encodings,
// bathysphere signal codes and the registered actuator decode.
package bath_lock_ctrl_pkg;

  typedef enum logic [3:0] {
    ST_IDLE, ST_PREP, ST_OPEN_ENTRY, ST_WAIT_IN, ST_CLOSE_ENTRY,
    ST_PRESS, ST_OPEN_EXIT, ST_WAIT_OUT, ST_CLOSE_EXIT
  } state_t;

  typedef enum logic {DIR_ARRIVE = 1'b0, DIR_DEPART = 1'b1} dir_t;

  localparam logic [1:0] BATH_SIG_IDLE   = 2'b00;
  localparam logic [1:0] BATH_SIG_ARRIVE = 2'b01;
  localparam logic [1:0] BATH_SIG_DEPART = 2'b10;

  typedef struct packed {
    logic       outer_open;
    logic       inner_open;
    logic       fill_on;
    logic       drain_on;
    logic [1:0] sig;
    logic       busy;
  } act_t;

  function automatic logic is_timed(state_t st);
    return st inside {ST_PREP, ST_OPEN_ENTRY, ST_CLOSE_ENTRY,
                      ST_PRESS, ST_OPEN_EXIT, ST_CLOSE_EXIT};
  endfunction

  function automatic logic is_pump(state_t st);
    return st inside {ST_PREP, ST_PRESS};
  endfunction

  // Arrival enters through the outer door, departure through the inner one.
  // PREP matches the entry side pressure, PRESS swaps to the exit side.
  function automatic act_t decode(state_t st, dir_t dir);
    act_t a;
    logic arr, entry_open, exit_open;
    a          = '0;
    arr        = (dir == DIR_ARRIVE);
    entry_open = st inside {ST_OPEN_ENTRY, ST_WAIT_IN};
    exit_open  = st inside {ST_OPEN_EXIT, ST_WAIT_OUT};
    if (st != ST_IDLE) begin
      a.busy = 1'b1;
      a.sig  = arr ? BATH_SIG_ARRIVE : BATH_SIG_DEPART;
    end
    a.outer_open = arr ? entry_open : exit_open;
    a.inner_open = arr ? exit_open  : entry_open;
    a.fill_on    = (st == ST_PREP && arr)  || (st == ST_PRESS && !arr);
    a.drain_on   = (st == ST_PREP && !arr) || (st == ST_PRESS && arr);
    return a;
  endfunction

endpackage

// File: rtl/bath_lock_ctrl_phase_timer.sv
// Shared phase timer: 4-bit count-up with synchronous clear and a
// terminal-count flag raised on the last cycle of a limit-cycle phase.
module bath_lock_ctrl_phase_timer (
  input  logic       clk,
  input  logic       reset,
  input  logic       clr,
  input  logic [3:0] limit,
  output logic [3:0] count,
  output logic       tc
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)   count <= '0;
    else if (clr) count <= '0;
    else          count <= count + 4'd1;
  end

  assign tc = (count == limit - 4'd1);

endmodule

// File: rtl/bath_lock_ctrl.sv
// Bathysphere lock chamber sequencer: arbitrates arrive/depart requests and
// drives doors, pumps and status with registered (Moore) outputs.
module bath_lock_ctrl
  import bath_lock_ctrl_pkg::*;
#(
  parameter int DOOR_CYCLES  = 5,
  parameter int PRESS_CYCLES = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       arrive_req,
  input  logic       depart_req,
  input  logic       sub_present,
  output logic       arrive_grant,
  output logic       depart_grant,
  output logic       outer_open,
  output logic       inner_open,
  output logic       fill_on,
  output logic       drain_on,
  output logic [1:0] bathysphereSignal,
  output logic       busy,
  output logic       done,
  output logic [3:0] timer
);

  localparam logic [3:0] DOOR_L  = 4'(DOOR_CYCLES);
  localparam logic [3:0] PRESS_L = 4'(PRESS_CYCLES);

  state_t     state, nxt;
  dir_t       dir, nxt_dir, last_dir;
  logic       wet, go, need_prep, tc, clr;
  logic [3:0] limit;
  act_t       act;

  // Timed states exit exactly on tc, so clearing on tc also zeroes the
  // count for a directly following timed state.
  assign clr   = !is_timed(state) || tc;
  assign limit = is_pump(state) ? PRESS_L : DOOR_L;

  bath_lock_ctrl_phase_timer u_timer (
    .clk  (clk),
    .reset(reset),
    .clr  (clr),
    .limit(limit),
    .count(timer),
    .tc   (tc)
  );

  always_comb begin
    nxt       = state;
    nxt_dir   = dir;
    go        = 1'b0;
    need_prep = 1'b0;
    case (state)
      ST_IDLE: if (arrive_req || depart_req) begin
        go = 1'b1;
        if (arrive_req && depart_req)
          nxt_dir = (last_dir == DIR_DEPART) ? DIR_ARRIVE : DIR_DEPART;
        else
          nxt_dir = arrive_req ? DIR_ARRIVE : DIR_DEPART;
        need_prep = (nxt_dir == DIR_ARRIVE) ? !wet : wet;
        nxt       = need_prep ? ST_PREP : ST_OPEN_ENTRY;
      end
      ST_PREP:        if (tc) nxt = ST_OPEN_ENTRY;
      ST_OPEN_ENTRY:  if (tc) nxt = ST_WAIT_IN;
      ST_WAIT_IN:     if (sub_present) nxt = ST_CLOSE_ENTRY;
      ST_CLOSE_ENTRY: if (tc) nxt = ST_PRESS;
      ST_PRESS:       if (tc) nxt = ST_OPEN_EXIT;
      ST_OPEN_EXIT:   if (tc) nxt = ST_WAIT_OUT;
      ST_WAIT_OUT:    if (!sub_present) nxt = ST_CLOSE_EXIT;
      ST_CLOSE_EXIT:  if (tc) nxt = ST_IDLE;
      default:        nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= ST_IDLE;
      dir          <= DIR_ARRIVE;
      last_dir     <= DIR_DEPART;
      wet          <= 1'b0;
      act          <= '0;
      arrive_grant <= 1'b0;
      depart_grant <= 1'b0;
      done         <= 1'b0;
    end else begin
      state        <= nxt;
      dir          <= nxt_dir;
      act          <= decode(nxt, nxt_dir);
      arrive_grant <= go && (nxt_dir == DIR_ARRIVE);
      depart_grant <= go && (nxt_dir == DIR_DEPART);
      done         <= (state == ST_CLOSE_EXIT) && (nxt == ST_IDLE);
      if (go) last_dir <= nxt_dir;
      if (tc && act.fill_on)  wet <= 1'b1;
      if (tc && act.drain_on) wet <= 1'b0;
    end
  end

  assign outer_open        = act.outer_open;
  assign inner_open        = act.inner_open;
  assign fill_on           = act.fill_on;
  assign drain_on          = act.drain_on;
  assign bathysphereSignal = act.sig;
  assign busy              = act.busy;

  // Chamber safety: one door at a time, and no door open while pumping.
  a_safe: assert property (@(posedge clk) disable iff (!reset)
    !(outer_open && inner_open) && !((outer_open || inner_open) && (fill_on || drain_on)));

endmodule
